// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for a 5-stage RV32I pipeline. It holds a
// direct-mapped table of 2-bit saturating direction counters and a tagged
// branch target buffer. Fetch is predicted combinationally. The instruction
// in Execute is resolved combinationally, and the table is updated on the
// rising edge.
//
// Ports
//   CLK                clock, all state changes on the rising edge
//   RST_N              synchronous active-low reset
//   pcF                PC in Fetch
//   predict_takenF     Fetch prediction: taken
//   predict_targetF    Fetch predicted target (0 when not predicted taken)
//   instr_validE       Execute holds a real instruction
//   branch_validE      Execute instruction is a branch / jal / jalr
//   pcE                PC of the Execute instruction
//   takenE             actual outcome
//   targetE            actual target
//   predictedE         prediction carried down with the instruction
//   predicted_targetE  predicted target carried down with the instruction
//   fail_predict       mispredict, flush F/D and D/E on the next edge
//   redirect_pc        correct next PC when fail_predict=1, else 0
//   branch_cnt         saturating count of resolved branches
//   miss_cnt           saturating count of mispredicts
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 13
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [PC_W-1:0] pcF,
    output logic            predict_takenF,
    output logic [PC_W-1:0] predict_targetF,
    input  logic            instr_validE,
    input  logic            branch_validE,
    input  logic [PC_W-1:0] pcE,
    input  logic            takenE,
    input  logic [PC_W-1:0] targetE,
    input  logic            predictedE,
    input  logic [PC_W-1:0] predicted_targetE,
    output logic            fail_predict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Flattened views of the per-entry state, used by the lookup muxes.
    logic [DEPTH-1:0][1:0]      w_ctr_all;
    logic [DEPTH-1:0]           w_valid_all;
    logic [DEPTH-1:0][TAG_W-1:0] w_tag_all;
    logic [DEPTH-1:0][PC_W-1:0] w_target_all;

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;

    assign w_idx_f = pcF[IDX_W+1:2];
    assign w_tag_f = pcF[PC_W-1:IDX_W+2];
    assign w_idx_e = pcE[IDX_W+1:2];
    assign w_tag_e = pcE[PC_W-1:IDX_W+2];

    // ---------------- prediction ----------------
    logic w_hit_f;
    logic w_pred_taken;

    assign w_hit_f      = w_valid_all[w_idx_f] && (w_tag_all[w_idx_f] == w_tag_f);
    assign w_pred_taken = w_hit_f && w_ctr_all[w_idx_f][1];

    assign predict_takenF  = RST_N && w_pred_taken;
    assign predict_targetF = (RST_N && w_pred_taken) ? w_target_all[w_idx_f] : '0;

    // ---------------- resolution ----------------
    logic            w_branch;
    logic            w_branch_miss;
    logic            w_false_hit;
    logic            w_fail;
    logic [PC_W-1:0] w_pc_plus4;

    assign w_branch      = instr_validE && branch_validE;
    assign w_branch_miss = w_branch &&
                           ((takenE != predictedE) ||
                            (takenE && predictedE && (predicted_targetE != targetE)));
    // A non-branch that was predicted taken means the BTB entry aliased onto
    // an ordinary instruction.
    assign w_false_hit   = instr_validE && !branch_validE && predictedE;
    assign w_fail        = w_branch_miss || w_false_hit;
    assign w_pc_plus4    = pcE + PC_W'(4);

    assign fail_predict = RST_N && w_fail;
    assign redirect_pc  = (RST_N && w_fail) ?
                          ((branch_validE && takenE) ? targetE : w_pc_plus4) : '0;

    // ---------------- counter next value ----------------
    // A tag mismatch on a valid entry means another branch owned it. Restart
    // the counter at a weak state instead of inheriting the old history.
    logic       w_replace;
    logic [1:0] w_ctr_cur;
    logic [1:0] w_ctr_next;

    assign w_ctr_cur = w_ctr_all[w_idx_e];
    assign w_replace = w_valid_all[w_idx_e] && (w_tag_all[w_idx_e] != w_tag_e);

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (w_replace) begin
            w_ctr_next = takenE ? 2'd2 : 2'd1;
        end else if (takenE) begin
            w_ctr_next = (w_ctr_cur == 2'd3) ? 2'd3 : w_ctr_cur + 2'd1;
        end else begin
            w_ctr_next = (w_ctr_cur == 2'd0) ? 2'd0 : w_ctr_cur - 2'd1;
        end
    end

    // ---------------- per-entry state ----------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [1:0]       r_ctr;
            logic             r_valid;
            logic [TAG_W-1:0] r_tag;
            logic [PC_W-1:0]  r_target;
            logic             w_sel;

            assign w_sel = (w_idx_e == IDX_W'(gi));

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_ctr    <= 2'b01;
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= '0;
                end else if (w_sel) begin
                    if (w_branch) begin
                        r_ctr <= w_ctr_next;
                    end
                    if (w_branch && takenE) begin
                        r_valid  <= 1'b1;
                        r_tag    <= w_tag_e;
                        r_target <= targetE;
                    end else if (w_false_hit) begin
                        r_valid  <= 1'b0;
                    end
                end
            end

            assign w_ctr_all[gi]    = r_ctr;
            assign w_valid_all[gi]  = r_valid;
            assign w_tag_all[gi]    = r_tag;
            assign w_target_all[gi] = r_target;
        end
    endgenerate

    // ---------------- statistics ----------------
    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else begin
            if (w_branch && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_fail && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt = r_branch_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule
